// File: rtl/rr_dff_write_arbiter.sv
// rr_dff_write_arbiter: round-robin write-side controller that shares a single
// W-bit register among N requesters. Each grant loads the winner's data into
// the register and owns it for HOLD cycles before priority rotates.
// Optional lock-and-hold ownership is compiled in when the macro
// RR_DFF_WRITE_ARBITER_LOCK_EN is defined (adds the 'lock' input).
module rr_dff_write_arbiter #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int HOLD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
`ifdef RR_DFF_WRITE_ARBITER_LOCK_EN
    input  logic [N-1:0]         lock,
`endif
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic [W-1:0]         q,
    output logic                 q_valid,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    gnt_d;
    logic [IW-1:0]   owner_d;
    logic [W-1:0]    q_d;
    logic            q_valid_d;

    logic [W-1:0]    wdata_arr [N];
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            lock_hold;
    logic            do_grant;
    logic            keep_ptr;
    logic [IW-1:0]   grant_idx;

    // Split the flat data bus into one word per requester.
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign wdata_arr[i] = wdata[i*W +: W];
    end

    // The current owner re-wins only when it holds both lock and request.
`ifdef RR_DFF_WRITE_ARBITER_LOCK_EN
    assign lock_hold = lock[owner] & req[owner];
`else
    assign lock_hold = 1'b0;
`endif

    // Round-robin search: first asserted request starting at ptr, wrapping mod N.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic; everything holds unless a grant or release occurs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt;
        owner_d   = owner;
        q_d       = q;
        q_valid_d = q_valid;
        do_grant  = 1'b0;
        keep_ptr  = 1'b0;
        grant_idx = win_idx;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    do_grant = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (lock_hold) begin
                    do_grant  = 1'b1;
                    keep_ptr  = 1'b1;
                    grant_idx = owner;
                end else if (win_found) begin
                    do_grant = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            state_d            = BUSY;
            gnt_d              = '0;
            gnt_d[grant_idx]   = 1'b1;
            owner_d            = grant_idx;
            q_d                = wdata_arr[grant_idx];
            q_valid_d          = 1'b1;
            cnt_d              = CW'(HOLD - 1);
            if (!keep_ptr) begin
                ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values and ordering cannot matter.
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            owner   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            owner   <= owner_d;
            q       <= q_d;
            q_valid <= q_valid_d;
        end
    end

    assign busy = (state_q == BUSY);

endmodule

// File: doc/rr_dff_write_arbiter.md
Name: rr_dff_write_arbiter

Overview:
- Round-robin scheduler sharing one W-bit D-flip-flop register (the shared resource) among N requesters.
- Grants one requester at a time and loads its data into the register.
- Holds the grant for a fixed HOLD-cycle occupancy window, then rotates priority.
- Sits in front of the flip-flop datapath blocks as their write-side controller.

Parameters:
- N, 4: number of requesters (≥2).
- W, 8: data/register width.
- HOLD, 2: cycles the register stays owned per grant (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  N  per-requester write request; level, held until granted.
- wdata  input  N*W  requester i data at bits [i*W +: W].
- gnt  output  N  one-hot grant, registered; all zero when idle.
- owner  output  clog2(N)  index of current/last grantee.
- q  output  W  shared register contents.
- q_valid  output  1  set after the first load, sticky until reset.
- busy  output  1  high while in BUSY.

Behaviour:
- Reset, at a clk edge with rst_n=0:
  - state=IDLE, ptr=0, cnt=0.
  - gnt=0, owner=0, q=0, q_valid=0, busy=0.
  - Overrides any in-progress grant; no write occurs on the reset edge.
- Winner selection: first i with req[i]=1, searching ptr, ptr+1, … mod N.
- IDLE:
  - If |req: go to BUSY; gnt<=onehot(winner), owner<=winner, q<=wdata[winner], q_valid<=1, cnt<=HOLD-1, ptr<=(winner+1) mod N.
  - Otherwise stay in IDLE; all outputs hold.
- BUSY:
  - gnt, owner and q hold; req changes are ignored, including deassertion by the owner (no abort).
  - If cnt≠0: cnt<=cnt-1.
  - If cnt==0 and |req: regrant immediately with no idle bubble, using the IDLE grant actions and the updated ptr.
  - If cnt==0 and !req: go to IDLE, gnt<=0; owner and q retain their values.
- Latency: req sampled at edge k → gnt/q valid after edge k; each grant lasts exactly HOLD cycles.
- Fairness: a continuously asserted request is granted within N-1 other grants.
- Requests arriving during BUSY are not lost; they compete at the cnt==0 edge.
- ptr wraps from N-1 to 0.
- HOLD=1: gnt may change every cycle.
- Only q is written, and only on grant edges.

Optional Feature:
- Macro RR_DFF_WRITE_ARBITER_LOCK_EN.
- When defined:
  - Adds input lock, width N.
  - At the cnt==0 edge in BUSY, if lock[owner]=1 and req[owner]=1, the same owner is regranted: q<=wdata[owner], cnt<=HOLD-1, ptr unchanged, other requesters wait.
  - lock is ignored in IDLE.
- When undefined:
  - No lock port; ownership always rotates per the round-robin rule.

Test Plan (N=4, W=8, HOLD=2):
- Reset then single request: rst_n=0 for 2 cycles, req=0100, wdata[2]=8'hA5.
  - Edge after: gnt=0100, q=A5, owner=2, q_valid=1, busy=1.
  - 2 cycles later, with req dropped: gnt=0000, busy=0, q=A5.
- All requesting continuously, req=1111, data 8'h10/11/12/13:
  - Grant order 0,1,2,3,0, each for 2 cycles, no idle cycles.
  - q follows 10,11,12,13,10.
- Owner drops req mid-grant: req[1] deasserted 1 cycle after grant.
  - gnt=0010 still held for the full 2 cycles.
  - Next grant goes to the next pending index ≥2.
- Synchronous reset mid-BUSY: rst_n=0 for one edge while gnt=1000.
  - After that edge: gnt=0, q=0, q_valid=0, ptr=0.
  - Asynchronous rst_n glitches between edges have no effect.
- Late arrival: req[3] rises during BUSY of owner 0 while req[1] is held.
  - Owner 1 is granted next (ptr=1), then 3.
- LOCK_EN build: lock[2]=1, req=0110.
  - Owner 2 is regranted 3 times consecutively, with q reloading wdata[2] each time.
  - Owner 1 is granted once lock[2]=0.
